// File: rtl/stopwatch_bcd.sv
// BCD stopwatch (mm:ss.hh) with synchronized push-buttons and a run/pause/clear FSM.
// Optional lap/freeze display enabled by defining STOPWATCH_BCD_LAP_EN.
module stopwatch_bcd (
    input  logic       CLOCK_10MHz,
    input  logic       RESET_N,
    input  logic       CLOCK_100Hz,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       LAP,
    output logic [7:0] HUNDREDTHS,
    output logic [7:0] SECONDS,
    output logic [7:0] MINUTES,
    output logic       RUNNING,
    output logic       LAP_HOLD,
    output logic       OVERFLOW
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // Digit order: [0] hundredths units ... [5] minutes tens.
    localparam logic [5:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

`ifdef STOPWATCH_BCD_LAP_EN
    localparam int NB = 3;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {LAP, CLEAR, START_STOP};
`else
    localparam int NB = 2;
    logic [NB-1:0] btn_raw;
    logic          unused_lap;
    assign btn_raw    = {CLEAR, START_STOP};
    assign unused_lap = LAP;
`endif

    state_t          state, state_nxt, state_mid;
    logic [NB-1:0]   btn_s1, btn_s2, btn_q, btn_ev;
    logic            clk_s1, clk_s2, tick;
    logic [5:0][3:0] cnt, cnt_nxt, inc;
    logic            carry, ovf_nxt, clear_act;
    logic            start_ev, clr_ev;

    assign btn_ev   = btn_s2 & ~btn_q;
    assign start_ev = btn_ev[0];
    assign clr_ev   = btn_ev[1];
    assign tick     = clk_s1 & ~clk_s2;

    always_ff @(posedge CLOCK_10MHz or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_mid = state;
        cnt_nxt   = cnt;
        ovf_nxt   = OVERFLOW;
        clear_act = 1'b0;
        inc       = cnt;
        carry     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (inc[i] == LIM[i]) begin
                    inc[i] = 4'd0;
                end else begin
                    inc[i] = inc[i] + 4'd1;
                    carry  = 1'b0;
                end
            end
        end
        // Tick is counted against the pre-edge state, before any button action.
        if (state == RUN && tick) begin
            cnt_nxt = inc;
            if (carry) ovf_nxt = 1'b1;
        end
        if (clr_ev && state != RUN) begin
            state_mid = IDLE;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
            clear_act = 1'b1;
        end
        state_nxt = state_mid;
        if (start_ev) begin
            case (state_mid)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_10MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_q    <= '0;
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            cnt      <= '0;
            OVERFLOW <= 1'b0;
            RUNNING  <= 1'b0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_q    <= btn_s2;
            clk_s1   <= CLOCK_100Hz;
            clk_s2   <= clk_s1;
            cnt      <= cnt_nxt;
            OVERFLOW <= ovf_nxt;
            RUNNING  <= (state_nxt == RUN);
        end
    end

`ifdef STOPWATCH_BCD_LAP_EN
    logic            lap_ev, hold_nxt;
    logic [5:0][3:0] snap, snap_nxt, disp, disp_nxt;

    assign lap_ev = btn_ev[2];

    always_comb begin
        hold_nxt = LAP_HOLD;
        snap_nxt = snap;
        if (clear_act) hold_nxt = 1'b0;
        if (lap_ev && state_mid != IDLE) hold_nxt = ~LAP_HOLD;
        if (hold_nxt && !LAP_HOLD) snap_nxt = cnt;
        disp_nxt = hold_nxt ? snap_nxt : cnt_nxt;
    end

    always_ff @(posedge CLOCK_10MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            LAP_HOLD <= 1'b0;
            snap     <= '0;
            disp     <= '0;
        end else begin
            LAP_HOLD <= hold_nxt;
            snap     <= snap_nxt;
            disp     <= disp_nxt;
        end
    end

    assign {MINUTES, SECONDS, HUNDREDTHS} = disp;
`else
    logic unused_clear_act;
    assign unused_clear_act = clear_act;
    assign LAP_HOLD = 1'b0;
    // Counter register is the display register when no snapshot exists.
    assign {MINUTES, SECONDS, HUNDREDTHS} = cnt;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd; lap checks follow STOPWATCH_BCD_LAP_EN.
module tb_stopwatch_bcd;
    logic       CLOCK_10MHz = 1'b0;
    logic       RESET_N     = 1'b0;
    logic       CLOCK_100Hz = 1'b0;
    logic       START_STOP  = 1'b0;
    logic       CLEAR       = 1'b0;
    logic       LAP         = 1'b0;
    logic [7:0] HUNDREDTHS, SECONDS, MINUTES;
    logic       RUNNING, LAP_HOLD, OVERFLOW;

    int errors = 0;
    int checks = 0;

    stopwatch_bcd dut (
        .CLOCK_10MHz(CLOCK_10MHz),
        .RESET_N    (RESET_N),
        .CLOCK_100Hz(CLOCK_100Hz),
        .START_STOP (START_STOP),
        .CLEAR      (CLEAR),
        .LAP        (LAP),
        .HUNDREDTHS (HUNDREDTHS),
        .SECONDS    (SECONDS),
        .MINUTES    (MINUTES),
        .RUNNING    (RUNNING),
        .LAP_HOLD   (LAP_HOLD),
        .OVERFLOW   (OVERFLOW)
    );

    always #50 CLOCK_10MHz = ~CLOCK_10MHz;

    function automatic logic [23:0] shown();
        return {MINUTES, SECONDS, HUNDREDTHS};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CLOCK_100Hz period; its tick is consumed before the task returns.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLOCK_10MHz) CLOCK_100Hz = 1'b1;
            repeat (2) @(negedge CLOCK_10MHz);
            CLOCK_100Hz = 1'b0;
            repeat (2) @(negedge CLOCK_10MHz);
        end
    endtask

    task automatic press(input bit s, input bit c, input bit l);
        @(negedge CLOCK_10MHz);
        START_STOP = s; CLEAR = c; LAP = l;
        repeat (4) @(negedge CLOCK_10MHz);
        START_STOP = 1'b0; CLEAR = 1'b0; LAP = 1'b0;
        repeat (3) @(negedge CLOCK_10MHz);
    endtask

    // Button and tick both reach the state logic on the same rising edge.
    task automatic tick_and_start();
        @(negedge CLOCK_10MHz) START_STOP = 1'b1;
        @(negedge CLOCK_10MHz) CLOCK_100Hz = 1'b1;
        repeat (2) @(negedge CLOCK_10MHz);
        CLOCK_100Hz = 1'b0;
        repeat (2) @(negedge CLOCK_10MHz);
        START_STOP = 1'b0;
        repeat (3) @(negedge CLOCK_10MHz);
    endtask

    initial begin
        repeat (2) @(negedge CLOCK_10MHz);
        check("reset_disp", shown(), 24'h000000);
        check("reset_run", RUNNING, 0);
        check("reset_ovf", OVERFLOW, 0);
        check("reset_lap", LAP_HOLD, 0);
        @(negedge CLOCK_10MHz) RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_10MHz);

        press(1, 0, 0);
        check("start_run", RUNNING, 1);
        tick(150);
        check("run150_disp", shown(), 24'h000150);
        check("run150_run", RUNNING, 1);
        check("run150_ovf", OVERFLOW, 0);

        // Preload near the end of range; running 360k ticks is not practical.
        @(negedge CLOCK_10MHz) force dut.cnt = 24'h595998;
        @(negedge CLOCK_10MHz) release dut.cnt;
        @(negedge CLOCK_10MHz);
        check("preload_disp", shown(), 24'h595998);
        tick(1);
        check("wrap_pre_disp", shown(), 24'h595999);
        check("wrap_pre_ovf", OVERFLOW, 0);
        tick(1);
        check("wrap_disp", shown(), 24'h000000);
        check("wrap_ovf", OVERFLOW, 1);
        check("wrap_run", RUNNING, 1);
        tick(1);
        check("wrap_post_disp", shown(), 24'h000001);
        check("ovf_sticky", OVERFLOW, 1);

        press(1, 0, 0);
        check("pause_run", RUNNING, 0);
        press(0, 1, 0);
        check("clear_disp", shown(), 24'h000000);
        check("clear_ovf", OVERFLOW, 0);

        press(1, 0, 0);
        tick(200);
        check("run200_disp", shown(), 24'h000200);
        press(1, 0, 0);
        tick(50);
        check("pause_hold_disp", shown(), 24'h000200);
        check("pause_hold_run", RUNNING, 0);
        press(0, 1, 0);
        check("clear2_disp", shown(), 24'h000000);
        check("clear2_ovf", OVERFLOW, 0);
        check("clear2_run", RUNNING, 0);

        press(1, 0, 0);
        tick(40);
        check("run40_disp", shown(), 24'h000040);
        press(0, 1, 0);
        check("clr_in_run_disp", shown(), 24'h000040);
        check("clr_in_run_run", RUNNING, 1);
        tick(1);
        check("clr_in_run_next", shown(), 24'h000041);

        press(1, 0, 0);
        press(1, 1, 0);
        check("both_run", RUNNING, 1);
        check("both_disp", shown(), 24'h000000);
        tick(1);
        check("both_next", shown(), 24'h000001);

        tick(8);
        check("run9_disp", shown(), 24'h000009);
        tick_and_start();
        check("tick_start_disp", shown(), 24'h000010);
        check("tick_start_run", RUNNING, 0);

        press(1, 0, 0);
        tick(5);
        check("run15_disp", shown(), 24'h000015);
        @(negedge CLOCK_10MHz);
        #10 RESET_N = 1'b0;
        START_STOP = 1'b1;
        #1;
        check("async_rst_disp", shown(), 24'h000000);
        check("async_rst_run", RUNNING, 0);
        check("async_rst_ovf", OVERFLOW, 0);
        @(negedge CLOCK_10MHz) RESET_N = 1'b1;
        repeat (6) @(negedge CLOCK_10MHz);
        check("held_btn_event", RUNNING, 1);
        START_STOP = 1'b0;
        repeat (4) @(negedge CLOCK_10MHz);
        check("held_btn_once", RUNNING, 1);
        check("held_btn_disp", shown(), 24'h000000);

        tick(325);
        check("run325_disp", shown(), 24'h000325);
`ifdef STOPWATCH_BCD_LAP_EN
        press(0, 0, 1);
        check("lap_hold_set", LAP_HOLD, 1);
        check("lap_freeze", shown(), 24'h000325);
        tick(100);
        check("lap_frozen100", shown(), 24'h000325);
        press(0, 0, 1);
        check("lap_hold_clr", LAP_HOLD, 0);
        check("lap_live", shown(), 24'h000425);
`else
        press(0, 0, 1);
        check("lap_ignored", LAP_HOLD, 0);
        tick(1);
        check("lap_live", shown(), 24'h000326);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
